// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG encoder block sequencing path.
package jpeg_enc_pkg;

  localparam int BLK_COEFS = 64;
  localparam int AC_LEN_W  = 6;
  localparam int COEF_W    = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    LOAD,
    DC,
    GO,
    SEND,
    WAIT
  } ac_rle_ctrl_state_e;

endpackage

// File: rtl/coef_blk_buf.sv
// One-block coefficient store: one write port, one read port with a registered,
// enable-gated read so the output holds between reads.
module coef_blk_buf
  import jpeg_enc_pkg::*;
#(
  parameter int WIDTH  = COEF_W,
  parameter int DEPTH  = BLK_COEFS,
  parameter int ADDR_W = AC_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the read register is reset; it drives a block output directly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ac_rle_ctrl.sv
// Block sequencer between the zigzag/quantiser output and the AC run-length
// encoder: loads 64 coefficients, emits DC, then streams AC 1..last-non-zero.
module ac_rle_ctrl
  import jpeg_enc_pkg::*;
#(
  parameter int COEF_WIDTH = 16,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  coef_valid_i,
  input  logic [COEF_WIDTH-1:0] coef_data_i,
  output logic                  coef_ready_o,
  output logic [COEF_WIDTH-1:0] dc_data_o,
  output logic                  dc_valid_o,
  output logic                  rle_data_go_o,
  output logic [LEN_WIDTH-1:0]  rle_data_len_o,
  output logic [COEF_WIDTH-1:0] rle_data_in_o,
  output logic                  rle_data_vld_o,
  input  logic                  rle_data_done_i,
  output logic                  busy_o
);

  localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(BLK_COEFS - 1);
  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);

  ac_rle_ctrl_state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  last_nz_q, last_nz_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COEF_WIDTH-1:0] dc_data_q, dc_data_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic                  send_last;
  logic                  rd_en;
  logic [LEN_WIDTH-1:0]  rd_addr;

  assign xfer      = coef_valid_i && (state_q == LOAD);
  assign send_last = (rd_ptr_q == len_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (xfer && (idx_q == LAST_IDX)) state_d = DC;
      DC:      state_d = GO;
      GO:      state_d = (len_q == '0) ? WAIT : SEND;
      SEND:    if (send_last) state_d = WAIT;
      WAIT:    if (rle_data_done_i || done_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Index 1 is addressed in GO so that buf[1] is on the read port for the first SEND cycle.
  always_comb begin
    coef_ready_o   = 1'b0;
    dc_valid_o     = 1'b0;
    rle_data_go_o  = 1'b0;
    rle_data_vld_o = 1'b0;
    busy_o         = 1'b1;
    rd_en          = 1'b0;
    rd_addr        = rd_ptr_q + ONE;
    unique case (state_q)
      LOAD: begin
        coef_ready_o = 1'b1;
        busy_o       = 1'b0;
      end
      DC:   dc_valid_o = 1'b1;
      GO: begin
        rle_data_go_o = 1'b1;
        rd_en         = 1'b1;
        rd_addr       = ONE;
      end
      SEND: begin
        rle_data_vld_o = 1'b1;
        rd_en          = !send_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    last_nz_d = last_nz_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    dc_data_d = dc_data_q;
    done_d    = done_q;
    if (xfer) begin
      idx_d = idx_q + ONE;
      if (idx_q == '0) begin
        dc_data_d = coef_data_i;
        last_nz_d = '0;
      end else if (coef_data_i != '0) begin
        last_nz_d = idx_q;
      end
    end
    if (state_q == DC) begin
      len_d = last_nz_q;
    end
    if (state_q == GO) begin
      rd_ptr_d = ONE;
    end else if ((state_q == SEND) && !send_last) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    // A done seen any time from GO onward is remembered until WAIT consumes it.
    if (state_q == GO) begin
      done_d = rle_data_done_i;
    end else if ((state_q == SEND) || (state_q == WAIT)) begin
      done_d = done_q || rle_data_done_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q     <= '0;
      last_nz_q <= '0;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      dc_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      last_nz_q <= last_nz_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      dc_data_q <= dc_data_d;
      done_q    <= done_d;
    end
  end

  coef_blk_buf #(
    .WIDTH  (COEF_WIDTH),
    .DEPTH  (BLK_COEFS),
    .ADDR_W (LEN_WIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (xfer),
    .wr_addr_i (idx_q),
    .wr_data_i (coef_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rle_data_in_o)
  );

  assign dc_data_o      = dc_data_q;
  assign rle_data_len_o = len_q;

endmodule
